// File: rtl/svm_seq_pkg.sv
// svm_seq_pkg: shared state encoding, Pendigits defaults and the error-class constant for the sample sequencer
package svm_seq_pkg;
  localparam int DEF_N_FEATURES = 17;
  localparam int DEF_INPUT_WIDTH = 4;
  localparam int DEF_CLASS_WIDTH = 4;
  typedef enum logic [1:0] {LOAD, WAIT, DONE} state_t;
  function automatic logic [31:0] err_class(input int w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/feature_shift_reg.sv
// feature_shift_reg: indexed write-enable word bank (clk, rst_n, we, idx, din -> q flat vector, word 0 in LSBs)
module feature_shift_reg #(
  parameter int N = 17,
  parameter int W = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IW-1:0]   idx,
  input  logic [W-1:0]    din,
  output logic [N*W-1:0]  q
);
  logic [N*W-1:0] q_q, q_d;
  always_comb begin
    q_d = q_q;
    if (we) q_d[idx*W +: W] = din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/svm_sample_sequencer.sv
// svm_sample_sequencer: loads feature words (in_valid/in_ready/in_data -> feats), runs the classifier (clf_rst_n, clf_ready, clf_class) and reports out_valid/out_class/out_err until out_ack
module svm_sample_sequencer
  import svm_seq_pkg::*;
#(
  parameter int N_features = DEF_N_FEATURES,
  parameter int inputWidth = DEF_INPUT_WIDTH,
  parameter int classWidth = DEF_CLASS_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [inputWidth-1:0]            in_data,
  output logic                             in_ready,
  output logic [N_features*inputWidth-1:0] feats,
  output logic                             clf_rst_n,
  input  logic                             clf_ready,
  input  logic [classWidth-1:0]            clf_class,
  output logic                             out_valid,
  output logic [classWidth-1:0]            out_class,
  output logic                             out_err,
  input  logic                             out_ack
);
  localparam int IW = N_features > 1 ? $clog2(N_features) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic clf_rst_n_q, clf_rst_n_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [classWidth-1:0] out_class_q, out_class_d;
  logic xfer, last;
  assign in_ready = state_q == LOAD;
  assign xfer = in_valid && in_ready;
  assign last = cnt_q == IW'(N_features - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wd_d = wd_q;
    out_class_d = out_class_q;
    out_err_d = out_err_q;
    case (state_q)
      LOAD: if (xfer) begin
        cnt_d = last ? '0 : cnt_q + IW'(1);
        state_d = last ? WAIT : LOAD;
      end
      WAIT: begin
        wd_d = (wd_q == '1) ? wd_q : wd_q + WW'(1);
        if (clf_ready) begin
          out_class_d = clf_class;
          out_err_d = 1'b0;
          state_d = DONE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          out_class_d = classWidth'(err_class(classWidth));
          out_err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (out_ack) begin
        wd_d = '0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    clf_rst_n_d = state_d == WAIT;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
      wd_q <= '0;
      clf_rst_n_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      clf_rst_n_q <= clf_rst_n_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_err_q <= out_err_d;
    end
  feature_shift_reg #(.N(N_features), .W(inputWidth)) u_feats (
    .clk(clk),
    .rst_n(rst_n),
    .we(xfer),
    .idx(cnt_q),
    .din(in_data),
    .q(feats)
  );
  assign clf_rst_n = clf_rst_n_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err = out_err_q;
endmodule

// File: tb/tb_svm_sample_sequencer.sv
// tb_svm_sample_sequencer: directed self-checking bench for the sample sequencer
module tb_svm_sample_sequencer;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, clf_rst_n, clf_ready = 0;
  logic out_valid, out_err, out_ack = 0;
  logic [3:0] in_data = 0, clf_class = 0, out_class;
  logic [67:0] feats, exp_feats;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  svm_sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .feats(feats), .clf_rst_n(clf_rst_n), .clf_ready(clf_ready), .clf_class(clf_class),
    .out_valid(out_valid), .out_class(out_class), .out_err(out_err), .out_ack(out_ack)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] base, input bit hold);
    for (int k = 0; k < 17; k++) begin
      in_valid = 1;
      in_data = base + 4'(k);
      exp_feats[k*4 +: 4] = base + 4'(k);
      step();
      if (k == 15) chk("clf_rst_n_before_last", clf_rst_n, 0);
    end
    in_valid = hold;
    chk("clf_rst_n_rise", clf_rst_n, 1);
    chk("in_ready_wait", in_ready, 0);
    chk("feats_sample", feats, exp_feats);
  endtask
  task automatic ack();
    out_ack = 1;
    step();
    out_ack = 0;
    chk("ack_out_valid", out_valid, 0);
    chk("ack_in_ready", in_ready, 1);
  endtask
  initial begin
    int n;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_feats", feats, 0);
    chk("rst_clf_rst_n", clf_rst_n, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    #10 rst_n = 1;
    step();
    send(4'h1, 0);
    chk("feats_lsb", feats[3:0], 4'h1);
    chk("feats_msb", feats[67:64], 4'h1);
    for (int i = 0; i < 30; i++) step();
    chk("wait_no_valid", out_valid, 0);
    clf_ready = 1;
    clf_class = 4'd7;
    step();
    clf_ready = 0;
    clf_class = 0;
    chk("ready_out_valid", out_valid, 1);
    chk("ready_out_class", out_class, 7);
    chk("ready_out_err", out_err, 0);
    chk("done_clf_rst_n", clf_rst_n, 0);
    for (int i = 0; i < 3; i++) step();
    chk("hold_out_valid", out_valid, 1);
    chk("hold_out_class", out_class, 7);
    ack();
    send(4'h2, 0);
    n = 0;
    while (!out_valid && n < 400) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_out_valid", out_valid, 1);
    chk("timeout_out_class", out_class, 4'hF);
    chk("timeout_out_err", out_err, 1);
    ack();
    send(4'h5, 0);
    for (int i = 0; i < 254; i++) step();
    chk("edge_no_valid_yet", out_valid, 0);
    clf_ready = 1;
    clf_class = 4'd5;
    step();
    clf_ready = 0;
    chk("edge_out_valid", out_valid, 1);
    chk("edge_out_class", out_class, 5);
    chk("edge_out_err", out_err, 0);
    ack();
    send(4'h4, 0);
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 0;
    #1;
    chk("rst_wait_clf_rst_n", clf_rst_n, 0);
    chk("rst_wait_in_ready", in_ready, 1);
    chk("rst_wait_feats", feats, 0);
    #1 rst_n = 1;
    step();
    for (int k = 0; k < 9; k++) begin
      in_valid = 1;
      in_data = 4'(k + 8);
      step();
    end
    in_valid = 0;
    chk("partial_feats", feats[35:0], 36'h0fedcba98);
    #2 rst_n = 0;
    #1;
    chk("rst_load_feats", feats, 0);
    chk("rst_load_in_ready", in_ready, 1);
    chk("rst_load_clf_rst_n", clf_rst_n, 0);
    #1 rst_n = 1;
    step();
    send(4'h3, 1);
    in_data = 4'hA;
    for (int i = 0; i < 5; i++) step();
    chk("wait_valid_ignored_feats", feats, exp_feats);
    chk("wait_valid_in_ready", in_ready, 0);
    clf_ready = 1;
    clf_class = 4'd2;
    step();
    clf_ready = 0;
    for (int i = 0; i < 4; i++) step();
    chk("done_valid_ignored_feats", feats, exp_feats);
    chk("done_out_class", out_class, 2);
    in_valid = 0;
    ack();
    chk("load_feats_retained", feats, exp_feats);
    out_ack = 1;
    clf_ready = 1;
    step();
    out_ack = 0;
    clf_ready = 0;
    chk("stray_ack_in_ready", in_ready, 1);
    chk("stray_ready_out_valid", out_valid, 0);
    chk("stray_clf_rst_n", clf_rst_n, 0);
    send(4'h9, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
